// File: rtl/mux_rr_param.sv
// mux_rr_param -- N-channel, WIDTH-bit registered multiplexer that merges
// channels ahead of the serialiser. The grant is chosen either by a fixed
// external selector (mode=0) or by round-robin arbitration across the valid
// channels (mode=1).
//
// Ports:
//   clok       rising-edge clock
//   reset      asynchronous active-high reset
//   mode       0 = fixed select, 1 = round-robin
//   selector   channel used in mode 0 (out of range grants nothing)
//   data_in    flat bus, channel k at [k*WIDTH +: WIDTH]
//   valid_in   per-channel valid
//   pop        combinational one-hot grant (source consumes its word)
//   data_out   registered data of the last grant
//   valid_out  registered; high the cycle after a grant
//   chan_out   registered index of the granted channel
//   grant_cnt  saturating 8-bit grant counter (only with MUX_STATS_EN)
//
// Optional feature macro: MUX_STATS_EN adds grant_cnt.
module mux_rr_param #(
  parameter  int WIDTH    = 2,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clok,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          selector,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]       valid_in,
`ifdef MUX_STATS_EN
  output logic [7:0]                grant_cnt,
`endif
  output logic [CHANNELS-1:0]       pop,
  output logic [WIDTH-1:0]          data_out,
  output logic                      valid_out,
  output logic [SEL_W-1:0]          chan_out
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

  logic [CHANNELS-1:0][WIDTH-1:0] din;
  logic                           gnt;
  logic [SEL_W-1:0]               gnt_chan;
  logic [SEL_W-1:0]               cand;

  logic [SEL_W-1:0] ptr_q,  ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic             vld_q,  vld_d;

  assign din = data_in;

  // Grant selection. Round-robin walks CHANNELS candidates starting one past
  // ptr; the wrap is an explicit compare so non power-of-two counts work.
  always_comb begin
    gnt      = 1'b0;
    gnt_chan = ptr_q;
    cand     = ptr_q;
    if (!mode) begin
      gnt_chan = selector;
      if ((selector <= LAST) && valid_in[selector]) gnt = 1'b1;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cand = (cand == LAST) ? '0 : cand + 1'b1;
        if (!gnt && valid_in[cand]) begin
          gnt      = 1'b1;
          gnt_chan = cand;
        end
      end
    end
  end

  // The source pops on the same cycle it is granted; suppressed during reset
  // so no source drops a word that will never be registered.
  always_comb begin
    pop = '0;
    if (gnt && !reset) pop[gnt_chan] = 1'b1;
  end

  // ptr follows every grant in both modes so a later switch to round-robin
  // continues from the last served channel.
  always_comb begin
    ptr_d  = ptr_q;
    data_d = data_q;
    chan_d = chan_q;
    vld_d  = gnt;
    if (gnt) begin
      ptr_d  = gnt_chan;
      data_d = din[gnt_chan];
      chan_d = gnt_chan;
    end
  end

  always_ff @(posedge clok or posedge reset) begin
    if (reset) begin
      ptr_q  <= LAST;
      data_q <= '0;
      chan_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      data_q <= data_d;
      chan_q <= chan_d;
      vld_q  <= vld_d;
    end
  end

  assign data_out  = data_q;
  assign chan_out  = chan_q;
  assign valid_out = vld_q;

`ifdef MUX_STATS_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (gnt && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clok or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mux_rr_param.sv
// Scoreboard bench for mux_rr_param: a 4-channel instance (A) and a
// 3-channel instance (B) sharing clock and reset. Stimulus checks pop and
// pushes the hand-computed registered response; per-instance monitors pop
// the queue each cycle after the edge and compare.
module tb_mux_rr_param;

  typedef struct packed {
    logic       v;
    logic [1:0] d;
    logic [1:0] c;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic       a_mode;
  logic [1:0] a_sel;
  logic [7:0] a_data;
  logic [3:0] a_valid, a_pop;
  logic [1:0] a_dout, a_chan;
  logic       a_vout;

  logic       b_mode;
  logic [1:0] b_sel;
  logic [5:0] b_data;
  logic [2:0] b_valid, b_pop;
  logic [1:0] b_dout, b_chan;
  logic       b_vout;

`ifdef MUX_STATS_EN
  logic [7:0] a_cnt, b_cnt;
`endif

  int   nvec = 0;
  int   nerr = 0;
  bit   ena  = 1'b0;
  bit   enb  = 1'b0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  mux_rr_param #(.WIDTH(2), .CHANNELS(4)) u_a (
    .clok(clk), .reset(rst), .mode(a_mode), .selector(a_sel),
    .data_in(a_data), .valid_in(a_valid),
`ifdef MUX_STATS_EN
    .grant_cnt(a_cnt),
`endif
    .pop(a_pop), .data_out(a_dout), .valid_out(a_vout), .chan_out(a_chan)
  );

  mux_rr_param #(.WIDTH(2), .CHANNELS(3)) u_b (
    .clok(clk), .reset(rst), .mode(b_mode), .selector(b_sel),
    .data_in(b_data), .valid_in(b_valid),
`ifdef MUX_STATS_EN
    .grant_cnt(b_cnt),
`endif
    .pop(b_pop), .data_out(b_dout), .valid_out(b_vout), .chan_out(b_chan)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus: drive on the falling edge, check pop, and queue
  // the registered response expected after the next rising edge.
  task automatic step(input bit is_b, input logic m, input logic [1:0] s,
                      input logic [3:0] v, input logic [3:0] ep,
                      input logic ev, input logic [1:0] ed, input logic [1:0] ec);
    exp_t e;
    @(negedge clk);
    if (is_b) begin
      b_mode = m; b_sel = s; b_valid = v[2:0];
    end else begin
      a_mode = m; a_sel = s; a_valid = v;
    end
    #1;
    chk(is_b ? "b_pop" : "a_pop", is_b ? {29'd0, b_pop} : {28'd0, a_pop}, {28'd0, ep});
    e = '{v: ev, d: ed, c: ec};
    if (is_b) begin qb.push_back(e); enb = 1'b1; end
    else      begin qa.push_back(e); ena = 1'b1; end
  endtask

  always @(posedge clk) begin : mon_a
    exp_t e;
    #2;
    if (ena) begin
      if (qa.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL a_sb: output with empty queue");
      end else begin
        e = qa.pop_front();
        chk("a_out{v,d,c}", {27'd0, a_vout, a_dout, a_chan}, {27'd0, e});
      end
    end
  end

  always @(posedge clk) begin : mon_b
    exp_t e;
    #2;
    if (enb) begin
      if (qb.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL b_sb: output with empty queue");
      end else begin
        e = qb.pop_front();
        chk("b_out{v,d,c}", {27'd0, b_vout, b_dout, b_chan}, {27'd0, e});
      end
    end
  end

  initial begin
    rst = 1'b1;
    a_mode = 1'b1; a_sel = 2'd0; a_valid = 4'b1111; a_data = 8'b00_11_10_01;
    b_mode = 1'b1; b_sel = 2'd0; b_valid = 3'b111;  b_data = 6'b11_10_01;
    repeat (2) @(negedge clk);
    chk("rst_a_pop",  {28'd0, a_pop}, 32'd0);
    chk("rst_b_pop",  {29'd0, b_pop}, 32'd0);
    chk("rst_a_vout", {31'd0, a_vout}, 32'd0);
    chk("rst_a_dout", {30'd0, a_dout}, 32'd0);
    chk("rst_a_chan", {30'd0, a_chan}, 32'd0);
    a_valid = '0; b_valid = '0;
    rst = 1'b0;

    // Instance A: round-robin from reset, fixed select, mixed patterns.
    step(0, 1, 0, 4'b1111, 4'b0001, 1, 2'b01, 0);
    step(0, 1, 0, 4'b1111, 4'b0010, 1, 2'b10, 1);
    step(0, 1, 0, 4'b1111, 4'b0100, 1, 2'b11, 2);
    step(0, 1, 0, 4'b1111, 4'b1000, 1, 2'b00, 3);
    step(0, 1, 0, 4'b1111, 4'b0001, 1, 2'b01, 0);
    step(0, 0, 2, 4'b0100, 4'b0100, 1, 2'b11, 2);
    step(0, 0, 0, 4'b0001, 4'b0001, 1, 2'b01, 0);
    step(0, 1, 0, 4'b1010, 4'b0010, 1, 2'b10, 1);
    step(0, 1, 0, 4'b1010, 4'b1000, 1, 2'b00, 3);
    step(0, 1, 0, 4'b1010, 4'b0010, 1, 2'b10, 1);
    step(0, 1, 0, 4'b1010, 4'b1000, 1, 2'b00, 3);
    step(0, 1, 0, 4'b0000, 4'b0000, 0, 2'b00, 3);
    step(0, 1, 0, 4'b0000, 4'b0000, 0, 2'b00, 3);
    step(0, 0, 1, 4'b0010, 4'b0010, 1, 2'b10, 1);
    step(0, 0, 1, 4'b0010, 4'b0010, 1, 2'b10, 1);
    step(0, 0, 3, 4'b0111, 4'b0000, 0, 2'b10, 1);
    step(0, 1, 0, 4'b0100, 4'b0100, 1, 2'b11, 2);
    step(0, 1, 0, 4'b0100, 4'b0100, 1, 2'b11, 2);
    step(0, 1, 0, 4'b1001, 4'b1000, 1, 2'b00, 3);
    step(0, 1, 0, 4'b1001, 4'b0001, 1, 2'b01, 0);
    step(0, 1, 0, 4'b0000, 4'b0000, 0, 2'b01, 0);
    @(posedge clk); #3; ena = 1'b0;

    // Instance B (3 channels): out-of-range selector, then mode switch.
    step(1, 0, 3, 4'b0111, 4'b0000, 0, 2'b00, 0);
    step(1, 0, 1, 4'b0111, 4'b0010, 1, 2'b10, 1);
    step(1, 1, 0, 4'b0111, 4'b0100, 1, 2'b11, 2);
    step(1, 1, 0, 4'b0111, 4'b0001, 1, 2'b01, 0);
    step(1, 1, 0, 4'b0000, 4'b0000, 0, 2'b01, 0);
    @(posedge clk); #3; enb = 1'b0;

    // Continuous grants on A, then asynchronous reset between edges.
`ifdef MUX_STATS_EN
    for (int i = 0; i < 300; i++) step(0, 0, 0, 4'b0001, 4'b0001, 1, 2'b01, 0);
`else
    for (int i = 0; i < 5; i++)   step(0, 0, 0, 4'b0001, 4'b0001, 1, 2'b01, 0);
`endif
    @(posedge clk); #3; ena = 1'b0;
`ifdef MUX_STATS_EN
    chk("grant_cnt_sat", {24'd0, a_cnt}, 32'd255);
`endif
    #1 rst = 1'b1;
    #1;
    chk("midrst_vout", {31'd0, a_vout}, 32'd0);
    chk("midrst_pop",  {28'd0, a_pop}, 32'd0);
    chk("midrst_dout", {30'd0, a_dout}, 32'd0);
`ifdef MUX_STATS_EN
    chk("midrst_cnt",  {24'd0, a_cnt}, 32'd0);
`endif
    @(negedge clk);
    a_valid = '0;
    rst = 1'b0;
    // After reset the pointer is back at the last channel: ch0 wins first.
    step(0, 1, 0, 4'b1111, 4'b0001, 1, 2'b01, 0);
    @(posedge clk); #3; ena = 1'b0;

    chk("qa_empty", qa.size(), 32'd0);
    chk("qb_empty", qb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
